// File: rtl/ibram_pkg.sv
// Shared types and width helpers for the multi-buffer input activation BRAM ring.
package ibram_pkg;

  typedef enum logic [1:0] {IDLE, FILL_BC, FILL_PAR} state_t;

  localparam logic MODE_BC  = 1'b0;
  localparam logic MODE_PAR = 1'b1;

  function automatic int buf_w(input int num_bufs);
    return (num_bufs < 2) ? 1 : $clog2(num_bufs);
  endfunction

  function automatic int len_w(input int write_depth);
    return $clog2(write_depth) + 1;
  endfunction

  function automatic int cnt_w(input int num_bufs);
    return $clog2(num_bufs + 1);
  endfunction

  function automatic int lane_w(input int ratio);
    return (ratio < 2) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/ibram_sdp_ram.sv
// Simple dual-port bank RAM: wide write port, narrow lane-selected read port
// with a registered read that holds its value between reads.
module ibram_sdp_ram #(
  parameter int WRITE_WIDTH = 128,
  parameter int READ_WIDTH  = 8,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int LANE_W      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [WRITE_WIDTH-1:0] wdata,
  input  logic                   re,
  input  logic [ADDR_W-1:0]      raddr,
  input  logic [LANE_W-1:0]      rlane,
  output logic [READ_WIDTH-1:0]  rdata
);

  logic [WRITE_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Lane 0 sits in the least significant bits of the stored word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr][rlane*READ_WIDTH +: READ_WIDTH];
  end

endmodule

// File: rtl/ibram_bank_ring.sv
// Per-bank ring of NUM_BUFS input buffers: writers fill and commit buffers,
// the reader consumes the oldest committed buffer and releases it.
module ibram_bank_ring
  import ibram_pkg::*;
#(
  parameter int NUM_BANKS   = 16,
  parameter int NUM_BUFS    = 2,
  parameter int WRITE_WIDTH = 128,
  parameter int WRITE_DEPTH = 128,
  parameter int READ_WIDTH  = 8,
  parameter int READ_DEPTH  = WRITE_WIDTH * WRITE_DEPTH / READ_WIDTH,
  localparam int BUF_W   = buf_w(NUM_BUFS),
  localparam int LEN_W   = len_w(WRITE_DEPTH),
  localparam int RADDR_W = $clog2(READ_DEPTH),
  localparam int CNT_W   = cnt_w(NUM_BUFS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_mode,
  input  logic [WRITE_WIDTH-1:0]         bc_data,
  input  logic                           bc_valid,
  input  logic [NUM_BANKS-1:0]           bc_bank_sel,
  input  logic [NUM_BANKS*WRITE_WIDTH-1:0] par_data,
  input  logic [NUM_BANKS-1:0]           par_valid,
  input  logic                           wr_done,
  output logic                           wr_ready,
  output logic                           rd_avail,
  output logic [BUF_W-1:0]               rd_buf,
  output logic [NUM_BANKS*LEN_W-1:0]     rd_len,
  input  logic [NUM_BANKS-1:0]           rd_en,
  input  logic [NUM_BANKS*RADDR_W-1:0]   rd_addr,
  output logic [NUM_BANKS*READ_WIDTH-1:0] rd_data,
  input  logic                           rd_release,
  output logic [CNT_W-1:0]               fill_count,
  output logic                           err_overflow,
  output logic                           err_underflow
);

  localparam int RATIO     = WRITE_WIDTH / READ_WIDTH;
  localparam int WA_W      = $clog2(WRITE_DEPTH);
  localparam int LANE_W    = lane_w(RATIO);
  localparam int ADDR_W    = BUF_W + WA_W;
  localparam int MEM_DEPTH = NUM_BUFS * WRITE_DEPTH;

  state_t                 state;
  logic [BUF_W-1:0]       wbuf;
  logic [BUF_W-1:0]       rbuf;
  logic [BUF_W-1:0]       wbuf_next;
  logic [BUF_W-1:0]       rbuf_next;
  logic [LEN_W-1:0]       cnt [NUM_BANKS];
  logic [LEN_W-1:0]       lengths [NUM_BUFS][NUM_BANKS];
  logic                   par_sel;
  logic [NUM_BANKS-1:0]   beat;
  logic [NUM_BANKS-1:0]   accept;
  logic [NUM_BANKS-1:0]   overflow_hit;
  logic                   commit;
  logic                   release_ok;

  assign wr_ready  = (fill_count != CNT_W'(NUM_BUFS));
  assign rd_avail  = (fill_count != '0);
  assign rd_buf    = rbuf;
  assign wbuf_next = (wbuf == BUF_W'(NUM_BUFS - 1)) ? '0 : wbuf + 1'b1;
  assign rbuf_next = (rbuf == BUF_W'(NUM_BUFS - 1)) ? '0 : rbuf + 1'b1;

  // The write source is latched by the FILL state; in IDLE wr_mode picks it.
  always_comb begin
    par_sel      = (state == FILL_PAR) || ((state == IDLE) && (wr_mode == MODE_PAR));
    beat         = '0;
    accept       = '0;
    overflow_hit = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      beat[b]         = wr_ready && (par_sel ? par_valid[b] : (bc_valid && bc_bank_sel[b]));
      accept[b]       = beat[b] && (cnt[b] != LEN_W'(WRITE_DEPTH));
      overflow_hit[b] = beat[b] && (cnt[b] == LEN_W'(WRITE_DEPTH));
    end
    commit     = wr_ready && wr_done && ((state != IDLE) || (|accept));
    release_ok = rd_release && rd_avail;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wbuf          <= '0;
      rbuf          <= '0;
      fill_count    <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) cnt[b] <= '0;
      for (int i = 0; i < NUM_BUFS; i++)
        for (int b = 0; b < NUM_BANKS; b++) lengths[i][b] <= '0;
    end else begin
      if (|overflow_hit) err_overflow <= 1'b1;
      if (!rd_avail && (rd_release || (|rd_en))) err_underflow <= 1'b1;

      if (commit) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
          lengths[wbuf][b] <= cnt[b] + LEN_W'(accept[b]);
          cnt[b]           <= '0;
        end
        wbuf  <= wbuf_next;
        state <= IDLE;
      end else begin
        for (int b = 0; b < NUM_BANKS; b++)
          if (accept[b]) cnt[b] <= cnt[b] + 1'b1;
        if ((state == IDLE) && (|accept))
          state <= (wr_mode == MODE_PAR) ? FILL_PAR : FILL_BC;
      end

      if (release_ok) rbuf <= rbuf_next;

      if (commit && !release_ok)      fill_count <= fill_count + 1'b1;
      else if (!commit && release_ok) fill_count <= fill_count - 1'b1;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [RADDR_W-1:0] addr_b;
    logic [ADDR_W-1:0]  waddr;
    logic [ADDR_W-1:0]  raddr;
    logic [LANE_W-1:0]  rlane;

    assign addr_b = rd_addr[b*RADDR_W +: RADDR_W];
    assign waddr  = {wbuf, cnt[b][WA_W-1:0]};
    assign raddr  = {rbuf, WA_W'(addr_b / RATIO)};
    assign rlane  = LANE_W'(addr_b % RATIO);
    assign rd_len[b*LEN_W +: LEN_W] = lengths[rbuf][b];

    ibram_sdp_ram #(
      .WRITE_WIDTH(WRITE_WIDTH),
      .READ_WIDTH (READ_WIDTH),
      .ADDR_W     (ADDR_W),
      .DEPTH      (MEM_DEPTH),
      .LANE_W     (LANE_W)
    ) u_ram (
      .clk  (clk),
      .rst  (rst),
      .we   (accept[b]),
      .waddr(waddr),
      .wdata(par_sel ? par_data[b*WRITE_WIDTH +: WRITE_WIDTH] : bc_data),
      .re   (rd_en[b] && rd_avail),
      .raddr(raddr),
      .rlane(rlane),
      .rdata(rd_data[b*READ_WIDTH +: READ_WIDTH])
    );
  end

endmodule

// File: tb/tb_ibram_bank_ring.sv
// Self-checking bench for ibram_bank_ring: a reference model of the ring plus
// a read scoreboard that queues expected read data and retires it a cycle later.
module tb_ibram_bank_ring;

  localparam int NB   = 16;
  localparam int NBUF = 3;
  localparam int WW   = 128;
  localparam int WD   = 128;
  localparam int RW   = 8;
  localparam int LW   = 8;
  localparam int AW   = 11;
  localparam int BW   = 2;
  localparam int CW   = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr_mode = 1'b0;
  logic [WW-1:0]   bc_data = '0;
  logic            bc_valid = 1'b0;
  logic [NB-1:0]   bc_bank_sel = '0;
  logic [NB*WW-1:0] par_data = '0;
  logic [NB-1:0]   par_valid = '0;
  logic            wr_done = 1'b0;
  logic            wr_ready;
  logic            rd_avail;
  logic [BW-1:0]   rd_buf;
  logic [NB*LW-1:0] rd_len;
  logic [NB-1:0]   rd_en = '0;
  logic [NB*AW-1:0] rd_addr = '0;
  logic [NB*RW-1:0] rd_data;
  logic            rd_release = 1'b0;
  logic [CW-1:0]   fill_count;
  logic            err_overflow;
  logic            err_underflow;

  ibram_bank_ring #(
    .NUM_BANKS(NB), .NUM_BUFS(NBUF), .WRITE_WIDTH(WW), .WRITE_DEPTH(WD), .READ_WIDTH(RW)
  ) dut (
    .clk(clk), .rst(rst), .wr_mode(wr_mode), .bc_data(bc_data), .bc_valid(bc_valid),
    .bc_bank_sel(bc_bank_sel), .par_data(par_data), .par_valid(par_valid),
    .wr_done(wr_done), .wr_ready(wr_ready), .rd_avail(rd_avail), .rd_buf(rd_buf),
    .rd_len(rd_len), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_release(rd_release), .fill_count(fill_count), .err_overflow(err_overflow),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state
  int          m_cnt [NB];
  int          m_len [NBUF][NB];
  int          m_wbuf, m_rbuf, m_fill, m_state;
  bit          m_ovf, m_unf;
  logic [WW-1:0] m_mem [NB][NBUF][WD];
  logic [RW-1:0] last_rd [NB];

  typedef struct packed {
    logic [31:0]   bank;
    logic [RW-1:0] val;
  } rd_exp_t;
  rd_exp_t sb[$];

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int b = 0; b < NB; b++) begin
      m_cnt[b]   = 0;
      last_rd[b] = '0;
      for (int i = 0; i < NBUF; i++) m_len[i][b] = 0;
    end
    m_wbuf = 0; m_rbuf = 0; m_fill = 0; m_state = 0;
    m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic checkStatus(input string tag);
    logic [127:0] exp_len;
    exp_len = '0;
    for (int b = 0; b < NB; b++) exp_len[b*LW +: LW] = LW'(m_len[m_rbuf][b]);
    checkOutput({tag, " wr_ready"}, wr_ready, m_fill < NBUF);
    checkOutput({tag, " rd_avail"}, rd_avail, m_fill != 0);
    checkOutput({tag, " rd_buf"}, rd_buf, m_rbuf);
    checkOutput({tag, " fill_count"}, fill_count, m_fill);
    checkOutput({tag, " rd_len"}, rd_len, exp_len);
    checkOutput({tag, " err_overflow"}, err_overflow, m_ovf);
    checkOutput({tag, " err_underflow"}, err_underflow, m_unf);
  endtask

  // One write/release cycle: update the model, drive the DUT, advance a cycle.
  task automatic applyStimulus(input logic bcv, input logic [NB-1:0] sel,
                               input logic [NB-1:0] pv, input logic done, input logic rel);
    bit ready, cur_par, any_acc, hit, commit, rel_ok;
    ready   = (m_fill < NBUF);
    cur_par = (m_state == 0) ? wr_mode : (m_state == 2);
    any_acc = 1'b0;
    if (ready) begin
      for (int b = 0; b < NB; b++) begin
        hit = cur_par ? pv[b] : (bcv && sel[b]);
        if (hit) begin
          if (m_cnt[b] == WD) m_ovf = 1'b1;
          else begin
            m_mem[b][m_wbuf][m_cnt[b]] = cur_par ? par_data[b*WW +: WW] : bc_data;
            m_cnt[b]++;
            any_acc = 1'b1;
          end
        end
      end
    end
    if (any_acc && m_state == 0) m_state = cur_par ? 2 : 1;
    commit = ready && done && (m_state != 0);
    rel_ok = rel && (m_fill != 0);
    if (rel && m_fill == 0) m_unf = 1'b1;
    if (commit) begin
      for (int b = 0; b < NB; b++) begin
        m_len[m_wbuf][b] = m_cnt[b];
        m_cnt[b] = 0;
      end
      m_wbuf  = (m_wbuf + 1) % NBUF;
      m_state = 0;
      m_fill++;
    end
    if (rel_ok) begin
      m_rbuf = (m_rbuf + 1) % NBUF;
      m_fill--;
    end
    bc_valid = bcv; bc_bank_sel = sel; par_valid = pv; wr_done = done; rd_release = rel;
    @(negedge clk);
    bc_valid = 1'b0; bc_bank_sel = '0; par_valid = '0; wr_done = 1'b0; rd_release = 1'b0;
  endtask

  task automatic readBank(input int b, input int addr);
    rd_exp_t e;
    logic [WW-1:0] word;
    word   = m_mem[b][m_rbuf][addr / (WW / RW)];
    e.bank = b;
    e.val  = word[(addr % (WW / RW))*RW +: RW];
    sb.push_back(e);
    rd_en = '0;
    rd_en[b] = 1'b1;
    rd_addr[b*AW +: AW] = AW'(addr);
    @(negedge clk);
    rd_en = '0;
    e = sb.pop_front();
    checkOutput($sformatf("read b%0d a%0d", b, addr), rd_data[e.bank*RW +: RW], e.val);
    last_rd[b] = e.val;
    @(negedge clk);
    checkOutput($sformatf("hold b%0d a%0d", b, addr), rd_data[e.bank*RW +: RW], e.val);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelReset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkStatus("reset");
    checkOutput("reset rd_data", rd_data, '0);

    // Broadcast fill: 3 beats to bank 2, 5 beats to bank 7
    wr_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bc_data = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(1'b1, 16'h0004, '0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      bc_data = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(1'b1, 16'h0080, '0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkStatus("bc");
    checkOutput("bc fill_count const", fill_count, 1);
    checkOutput("bc rd_buf const", rd_buf, 0);
    checkOutput("bc rd_len const", rd_len, (128'h5 << 56) | (128'h3 << 16));
    readBank(2, 0);
    readBank(2, 2*16 + 15);
    readBank(7, 4*16 + 3);
    readBank(7, 1*16 + 9);

    // Parallel fill: word value = bank*16 + beat
    wr_mode = 1'b1;
    for (int beat = 0; beat < 4; beat++) begin
      for (int b = 0; b < NB; b++) par_data[b*WW +: WW] = WW'(b*16 + beat);
      bc_data = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(1'b1, 16'hffff, 16'hffff, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkStatus("par");
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    checkStatus("par release");
    checkOutput("par rd_buf const", rd_buf, 1);
    readBank(3, 17);
    checkOutput("par b3 a17 const", rd_data[3*RW +: RW], 8'h00);
    readBank(3, 16);
    checkOutput("par b3 a16 const", rd_data[3*RW +: RW], 8'h31);
    readBank(15, 3*16);

    // Ring full: commit until three buffers are held, then try an extra beat
    wr_mode = 1'b0;
    bc_data = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(1'b1, 16'h0001, '0, 1'b1, 1'b0);
    bc_data = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(1'b1, 16'h0003, '0, 1'b0, 1'b0);
    bc_data = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(1'b1, 16'h0002, '0, 1'b1, 1'b0);
    checkStatus("full");
    checkOutput("full wr_ready const", wr_ready, 0);
    bc_data = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(1'b1, 16'h0001, '0, 1'b1, 1'b0);
    checkStatus("full drop");
    checkOutput("full drop fill const", fill_count, 3);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    checkStatus("full release");
    checkOutput("full release wr_ready const", wr_ready, 1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    checkStatus("second release");
    readBank(1, 5);

    // Beat + wr_done + rd_release in the same cycle at fill_count 1
    for (int i = 0; i < 3; i++) begin
      bc_data = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(1'b1, 16'h0020, '0, (i == 2), (i == 2));
    end
    checkStatus("simul");
    checkOutput("simul fill const", fill_count, 1);
    checkOutput("simul len5 const", rd_len[5*LW +: LW], 3);
    readBank(5, 2*16);

    // Overflow: WRITE_DEPTH+1 beats to bank 0
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i <= WD; i++) begin
      bc_data = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(1'b1, 16'h0001, '0, 1'b0, 1'b0);
    end
    checkOutput("ovf flag const", err_overflow, 1);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkStatus("ovf");
    checkOutput("ovf len0 const", rd_len[LW-1:0], 8'h80);
    readBank(0, 127*16 + 15);

    // Underflow: release with nothing committed
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    checkStatus("unf");
    checkOutput("unf flag const", err_underflow, 1);

    // Asynchronous reset in the middle of a fill
    for (int i = 0; i < 2; i++) begin
      bc_data = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(1'b1, 16'h0010, '0, 1'b0, 1'b0);
    end
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkStatus("reset mid");
    checkOutput("reset mid rd_data", rd_data, '0);
    @(negedge clk);
    rst = 1'b0;
    bc_data = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(1'b1, 16'h0010, '0, 1'b1, 1'b0);
    checkStatus("after reset");
    checkOutput("after reset len4 const", rd_len[4*LW +: LW], 1);
    readBank(4, 0);

    // Read strobe with no committed buffer: ignored, flagged, data holds
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    rd_en = 16'h0010;
    rd_addr[4*AW +: AW] = AW'(5);
    @(negedge clk);
    rd_en = '0;
    m_unf = 1'b1;
    checkStatus("rd unf");
    checkOutput("rd unf hold", rd_data[4*RW +: RW], last_rd[4]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
